// File: rtl/multiplier_multicycle.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, signed/unsigned, 2*WIDTH-bit product.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module multiplier_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 valid,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_c;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic                 r_done;

  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mplier_next;
  logic                 w_last;

  // Magnitudes are taken as unsigned, so abs of the most negative value stays exact.
  assign w_a_abs       = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_abs       = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
  assign w_last = (w_mplier_next == '0) || (r_count == CW'(WIDTH-1));
`else
  assign w_last = (r_count == CW'(WIDTH-1));
`endif

  assign done = r_done;
  assign c    = r_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_c      <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        // DONE shares the accept path with IDLE so a new op can start without a bubble.
        S_IDLE, S_DONE: begin
          if (valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
            r_mplier <= w_b_abs;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= S_BUSY;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_c     <= r_neg ? -w_acc_next : w_acc_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_multicycle.sv
// Scoreboard bench for multiplier_multicycle: driver pushes expected product and done cycle,
// an independent monitor pops and compares on every done and checks c is held in between.
module tb_multiplier_multicycle;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [63:0] c;

  multiplier_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .done      (done),
    .c         (c)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int unsigned done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] last_c;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the interpreted operands.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'({32'd0, x}) * longint'({32'd0, y});
    return 64'(p);
  endfunction

  function automatic int unsigned ref_steps(input logic [31:0] y, input logic s);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int unsigned n;
    m = (s && y[31]) ? (32'd0 - y) : y;
    n = 1;
    for (int unsigned i = 0; i < 32; i++)
      if (m[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1; the DUT must be in IDLE or DONE at the next edge. Returns in the DONE cycle.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic [63:0] req, input logic use_req);
    exp_t e;
    bit   seen;
    valid = 1'b1; a = x; b = y; is_signed = s;
    @(posedge clk); #1;
    e.prod     = use_req ? req : ref_mul(x, y, s);
    e.done_cyc = cyc + ref_steps(y, s);
    exp_q.push_back(e);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      valid = 1'($urandom); a = $urandom; b = $urandom; is_signed = 1'($urandom);
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    valid = 1'b0;
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within 40 cycles, a=0x%08h b=0x%08h", x, y);
    end
  endtask

  task automatic idle(input int unsigned n);
    valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor
  initial begin
    exp_t e;
    last_c = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        exp_q.delete();
        last_c = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("product", c, e.prod);
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          last_c = e.prod;
        end
      end else begin
        check("c_hold", c, last_c);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; valid = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 64'(done), 64'd0);
    check("reset_c", c, 64'd0);
    resetn = 1'b1;
    idle(2);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
    idle(4);
    issue(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    issue(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, 1'b1);
    idle(1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
    issue(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    idle(2);
    issue(32'd2, 32'd3, 1'b0, 64'd6, 1'b1);
    issue(32'd5, 32'd5, 1'b0, 64'd25, 1'b1);
    idle(2);
    issue(32'hDEAD_BEEF, 32'd1, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b1);
    issue(32'hDEAD_BEEF, 32'd0, 1'b0, 64'd0, 1'b1);
    issue(32'h0000_0003, 32'h0001_0000, 1'b0, 64'h0000_0000_0003_0000, 1'b1);
    issue(32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    idle(3);

    // Reset in the middle of an operation: result discarded, no done afterwards.
    valid = 1'b1; a = 32'h1234; b = 32'h5678; is_signed = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_c", c, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(40);
    issue(32'h1234, 32'h5678, 1'b0, 64'h0000_0000_0626_0060, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      issue(rnd_op(), rnd_op(), 1'($urandom), 64'd0, 1'b0);
    end
    idle(5);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multiplier_multicycle.md
Name: multiplier_multicycle

Overview:
Iterative shift-add 32x32 multiplier with a 64-bit product. It is the multiply counterpart of the team's multicycle divider and uses the same valid/done/c handshake, so the execute stage can drive both units the same way. It serves MIPS MULT/MULTU: c[63:32] goes to HI and c[31:0] goes to LO. It processes one multiplier bit per cycle and supports signed and unsigned operands.

Parameters:
WIDTH, 32, operand width; product width is 2*WIDTH. Only 32 is verified.

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  reset, synchronous, active-low
valid  in  1  start request; sampled only in IDLE or DONE
is_signed  in  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with valid
a  in  32  multiplicand; sampled at accept
b  in  32  multiplier; sampled at accept
done  out  1  high for exactly one cycle when c holds a new product
c  out  64  product {hi, lo}; held until the next completion

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE, done=0, c=0, internal registers cleared. This applies mid-operation too: the in-flight product is discarded and no done is produced.
- States: IDLE, BUSY, DONE (2-bit encoding).
- Accept: valid=1 while in IDLE or DONE at clock edge T. The unit then:
  - latches mcand = zero-extend-to-64(|a|) and mplier = |b|; abs() is applied only when is_signed=1;
  - latches neg = is_signed & (a[31]^b[31]);
  - clears acc (64 bits) and sets count=0;
  - enters BUSY.
- After accept, a, b and is_signed may change freely.
- BUSY, one step per cycle:
  - if mplier[0], acc += mcand (mod 2^64);
  - mcand <<= 1; mplier >>= 1; count++.
- Base latency: 32 BUSY steps. On the edge that completes the last step, c <= neg ? -(acc_next) : acc_next, and state becomes DONE.
- Timing: accept at edge T; BUSY occupies cycles T+1..T+32; DONE (done=1) in cycle T+33.
- DONE lasts one cycle:
  - valid=1 → accept the new operation and go to BUSY (back-to-back, no idle bubble);
  - otherwise → IDLE.
- done=0 in IDLE and BUSY. done is registered (state==DONE), not combinational from inputs.
- valid during BUSY is ignored. No queueing; the requester holds valid until it observes done.
- abs(0x80000000) = 0x80000000 as a 32-bit unsigned value; the magnitude math is exact for all inputs.
- 0x80000000*0x80000000 signed = 0x4000000000000000.
- Zero operand: the result is 0 with the normal latency.
- c changes only at a completion edge or at reset.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: in BUSY, if mplier_next==0 after a step, that step is the last. c is written and DONE is entered on the same edge. The BUSY cycle count becomes max(1, msb_index(|b|)+1). Examples: b=0 → 1 step; b=1 → 1 step; b=0x00010000 → 17 steps; b=0xFFFFFFFF → 32 steps. Results are identical to the non-early-exit build.
- Undefined: fixed 32 BUSY steps for every operation; the mplier==0 check is not synthesised.

Test Plan:
1. Unsigned max: is_signed=0, a=0xFFFFFFFF, b=0xFFFFFFFF, valid at T → done=1 only in cycle T+33, c=0xFFFFFFFE00000001, c held in later cycles.
2. Signed mixed: is_signed=1, a=0xFFFFFFFD (-3), b=7 → c=0xFFFFFFFFFFFFFFEB. Same operands with is_signed=0 → c=0x00000006FFFFFFEB.
3. Signed corner: is_signed=1, a=b=0x80000000 → c=0x4000000000000000. Also a=0x80000000, b=1 → c=0xFFFFFFFF80000000.
4. Back-to-back and operand hold:
   - valid held high with a=2, b=3;
   - in BUSY, toggle a/b randomly → result is unaffected;
   - in the DONE cycle present a=5, b=5 → first c=6, second op accepted with no IDLE cycle, done again 33 cycles later with c=25.
5. Reset mid-op: accept a=0x1234, b=0x5678, assert resetn=0 at step 10 → next cycle state=IDLE, done=0, c=0. After release, no spurious done.
6. MULT_EARLY_EXIT_EN build: b=1, a=0xDEADBEEF, accept at T → done at T+2, c=0x00000000DEADBEEF. b=0 → done at T+2, c=0. Non-EN build with the same stimulus → done at T+33, same c.
